// File: rtl/eva_axi_rd_rbuf.sv
// R-channel elastic buffer: skid FIFO plus registered output stage, in-order.
// Optional per-burst arlen/rlast checker enabled by defining EVA_RBUF_LEN_CHK_EN.
module eva_axi_rd_rbuf #(
    parameter int DW        = 128,
    parameter int IDW       = 6,
    parameter int UW        = 5,
    parameter int DEPTH     = 8,
    parameter int CMD_DEPTH = 4
) (
    input  logic                     aclk,
    input  logic                     arest,
    input  logic                     ar_hs,
    input  logic [5:0]               ar_len,
    input  logic                     s_rvalid,
    output logic                     s_rready,
    input  logic [IDW-1:0]           s_rid,
    input  logic [UW-1:0]            s_ruser,
    input  logic [DW-1:0]            s_rdata,
    input  logic                     s_rlast,
    input  logic [1:0]               s_rresp,
    output logic                     m_rvalid,
    input  logic                     m_rready,
    output logic [IDW-1:0]           m_rid,
    output logic [UW-1:0]            m_ruser,
    output logic [DW-1:0]            m_rdata,
    output logic                     m_rlast,
    output logic [1:0]               m_rresp,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err_len,
    output logic                     err_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = IDW + UW + DW + 3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_VALID = 1'b1
    } ost_e;

    ost_e          state_q, state_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] fcnt_q, fcnt_d;
    logic [LW-1:0] level_q, level_d;
    logic [EW-1:0] out_q, out_d;
    logic [EW-1:0] s_beat;
    logic          push, pop, load, from_mem, mem_wr;

    assign s_beat   = {s_rid, s_ruser, s_rdata, s_rlast, s_rresp};
    assign s_rready = !arest && (level_q < LW'(DEPTH));
    assign push     = s_rvalid && s_rready;
    assign pop      = m_rvalid && m_rready;

    // Output register can take a new beat when empty or being popped now.
    assign load     = (state_q == ST_EMPTY) || m_rready;
    assign from_mem = load && (fcnt_q != '0);
    assign mem_wr   = push && !(load && (fcnt_q == '0));

    always_ff @(posedge aclk) begin
        if (arest) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) state_d = ST_VALID;
            end
            ST_VALID: begin
                if (pop && (fcnt_q == '0) && !push) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        m_rvalid = (state_q == ST_VALID);
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        out_d   = out_q;
        fcnt_d  = fcnt_q + LW'(mem_wr) - LW'(from_mem);
        level_d = level_q + LW'(push) - LW'(pop);
        if (mem_wr) wptr_d = wptr_q + AW'(1);
        if (from_mem) begin
            out_d  = mem_q[rptr_q];
            rptr_d = rptr_q + AW'(1);
        end else if (load && push) begin
            out_d = s_beat;
        end
    end

    always_ff @(posedge aclk) begin
        if (arest) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            fcnt_q  <= '0;
            level_q <= '0;
            out_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            fcnt_q  <= fcnt_d;
            level_q <= level_d;
            out_q   <= out_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (mem_wr) mem_q[wptr_q] <= s_beat;
    end

    assign {m_rid, m_ruser, m_rdata, m_rlast, m_rresp} = out_q;
    assign level = level_q;

`ifdef EVA_RBUF_LEN_CHK_EN
    localparam int CAW = $clog2(CMD_DEPTH);

    logic [5:0]     cq_q [CMD_DEPTH];
    logic [CAW-1:0] cwp_q, cwp_d;
    logic [CAW-1:0] crp_q, crp_d;
    logic [CAW:0]   ccnt_q, ccnt_d;
    logic [5:0]     bcnt_q, bcnt_d;
    logic [5:0]     head;
    logic           elen_q, elen_d;
    logic           eovf_q, eovf_d;
    logic           cq_empty, cq_full, cq_pop, cq_push;

    assign head     = cq_q[crp_q];
    assign cq_empty = (ccnt_q == '0);
    assign cq_full  = (ccnt_q == (CAW+1)'(CMD_DEPTH));
    assign cq_pop   = push && s_rlast && !cq_empty;
    // A full queue still accepts an AR when its head retires this cycle.
    assign cq_push  = ar_hs && (!cq_full || cq_pop);

    always_comb begin
        elen_d = elen_q;
        eovf_d = eovf_q;
        bcnt_d = bcnt_q;
        cwp_d  = cwp_q + CAW'(cq_push);
        crp_d  = crp_q + CAW'(cq_pop);
        ccnt_d = ccnt_q + (CAW+1)'(cq_push) - (CAW+1)'(cq_pop);
        if (push) begin
            if (cq_empty) begin
                eovf_d = 1'b1;
            end else if (s_rlast != (bcnt_q == head)) begin
                elen_d = 1'b1;
            end
            bcnt_d = s_rlast ? 6'd0 : bcnt_q + 6'd1;
        end
        if (ar_hs && !cq_push) eovf_d = 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (arest) begin
            cwp_q  <= '0;
            crp_q  <= '0;
            ccnt_q <= '0;
            bcnt_q <= '0;
            elen_q <= 1'b0;
            eovf_q <= 1'b0;
        end else begin
            cwp_q  <= cwp_d;
            crp_q  <= crp_d;
            ccnt_q <= ccnt_d;
            bcnt_q <= bcnt_d;
            elen_q <= elen_d;
            eovf_q <= eovf_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (cq_push) cq_q[cwp_q] <= ar_len;
    end

    assign err_len = elen_q;
    assign err_ovf = eovf_q;
`else
    logic unused_ar;
    assign unused_ar = ^{ar_hs, ar_len} ^ (CMD_DEPTH > 0);
    assign err_len   = 1'b0;
    assign err_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_eva_axi_rd_rbuf.sv
// Bench for eva_axi_rd_rbuf: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of accepted beats.
module tb_eva_axi_rd_rbuf;

    localparam int DW        = 128;
    localparam int IDW       = 6;
    localparam int UW        = 5;
    localparam int DEPTH     = 8;
    localparam int CMD_DEPTH = 4;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [UW-1:0]  user;
        logic [DW-1:0]  data;
        logic           last;
        logic [1:0]     resp;
    } beat_t;

    logic           clk = 1'b0;
    logic           arest = 1'b1;
    logic           ar_hs = 1'b0;
    logic [5:0]     ar_len = '0;
    logic           s_rvalid = 1'b0;
    logic           s_rready;
    logic [IDW-1:0] s_rid = '0;
    logic [UW-1:0]  s_ruser = '0;
    logic [DW-1:0]  s_rdata = '0;
    logic           s_rlast = 1'b0;
    logic [1:0]     s_rresp = '0;
    logic           m_rvalid;
    logic           m_rready = 1'b0;
    logic [IDW-1:0] m_rid;
    logic [UW-1:0]  m_ruser;
    logic [DW-1:0]  m_rdata;
    logic           m_rlast;
    logic [1:0]     m_rresp;
    logic [3:0]     level;
    logic           err_len;
    logic           err_ovf;

    always #5 clk = ~clk;

    eva_axi_rd_rbuf #(
        .DW(DW), .IDW(IDW), .UW(UW), .DEPTH(DEPTH), .CMD_DEPTH(CMD_DEPTH)
    ) dut (
        .aclk(clk), .arest(arest), .ar_hs(ar_hs), .ar_len(ar_len),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid),
        .s_ruser(s_ruser), .s_rdata(s_rdata), .s_rlast(s_rlast),
        .s_rresp(s_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rid(m_rid), .m_ruser(m_ruser), .m_rdata(m_rdata),
        .m_rlast(m_rlast), .m_rresp(m_rresp), .level(level),
        .err_len(err_len), .err_ovf(err_ovf)
    );

    beat_t q[$];
    int    lq[$];
    logic [5:0] bcnt_m = '0;
    logic  elen_m = 1'b0;
    logic  eovf_m = 1'b0;
    int    n_pass = 0;
    int    n_chk = 0;
    bit    chk_en = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Model of accepted-but-undelivered beats and of the AR length bookkeeping.
    task automatic model_upd();
        int    n;
        bit    push, pop, cpop;
        beat_t b;
        n = q.size();
        if (arest) begin
            q.delete();
            lq.delete();
            bcnt_m = '0;
            elen_m = 1'b0;
            eovf_m = 1'b0;
        end else begin
            push = s_rvalid && (n < DEPTH);
            pop  = m_rready && (n > 0);
            b    = {s_rid, s_ruser, s_rdata, s_rlast, s_rresp};
            cpop = 1'b0;
            if (push) begin
                if (lq.size() == 0) eovf_m = 1'b1;
                else if (s_rlast ? (int'(bcnt_m) != lq[0]) : (int'(bcnt_m) == lq[0])) elen_m = 1'b1;
                if (s_rlast && lq.size() > 0) cpop = 1'b1;
                bcnt_m = s_rlast ? 6'd0 : bcnt_m + 6'd1;
            end
            if (cpop) void'(lq.pop_front());
            if (ar_hs) begin
                if (lq.size() < CMD_DEPTH) lq.push_back(int'(ar_len));
                else eovf_m = 1'b1;
            end
            if (pop) void'(q.pop_front());
            if (push) q.push_back(b);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_upd();
        #1;
    endtask

    task automatic do_reset();
        s_rvalid = 1'b0;
        ar_hs    = 1'b0;
        arest    = 1'b1;
        step();
        arest    = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic last);
        s_rvalid = 1'b1;
        s_rdata  = d;
        s_rlast  = last;
        step();
    endtask

    always @(negedge clk) begin
        logic exp_len, exp_ovf;
`ifdef EVA_RBUF_LEN_CHK_EN
        exp_len = elen_m;
        exp_ovf = eovf_m;
`else
        exp_len = 1'b0;
        exp_ovf = 1'b0;
`endif
        if (chk_en) begin
            chk("s_rready", s_rready, !arest && (q.size() < DEPTH));
            chk("m_rvalid", m_rvalid, q.size() > 0);
            chk("level", level, q.size());
            if (q.size() > 0)
                chk("payload", {m_rid, m_ruser, m_rdata, m_rlast, m_rresp}, q[0]);
            chk("err_len", err_len, exp_len);
            chk("err_ovf", err_ovf, exp_ovf);
        end
    end

    initial begin
        arest = 1'b1;
        step();
        chk_en = 1'b1;
        chk("rst_level", level, 0);
        chk("rst_mvalid", m_rvalid, 0);
        chk("rst_mrdata", m_rdata, 0);
        chk("rst_srready", s_rready, 0);
        arest = 1'b0;
        #1;
        chk("srready_post_rst", s_rready, 1);

        // Single burst of 4, sink always ready.
        m_rready = 1'b1;
        s_rid    = 6'd5;
        ar_hs    = 1'b1;
        ar_len   = 6'd3;
        step();
        ar_hs = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send(DW'(i), i == 4);
            chk("burst_valid", m_rvalid, 1);
            chk("burst_data", m_rdata, i);
        end
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        step();
        chk("burst_level", level, 0);
        chk("burst_err_len", err_len, 0);

        // Backpressure: fill to DEPTH, hold, then drain.
        m_rready = 1'b0;
        for (int i = 0; i < 8; i++) send(DW'(256 + i), i == 7);
        chk("bp_level_full", level, 8);
        chk("bp_srready_full", s_rready, 0);
        send(DW'(999), 1'b0);
        chk("bp_level_hold", level, 8);
        chk("bp_head_hold", m_rdata, 256);
        s_rvalid = 1'b0;
        m_rready = 1'b1;
        step();
        chk("bp_srready_pop", s_rready, 1);
        chk("bp_level_pop", level, 7);
        chk("bp_next_head", m_rdata, 257);
        repeat (7) step();
        chk("bp_drained", level, 0);

        // Reset with beats in flight.
        m_rready = 1'b0;
        for (int i = 0; i < 5; i++) send(DW'(512 + i), 1'b0);
        chk("mid_level", level, 5);
        do_reset();
        chk("mid_rst_mvalid", m_rvalid, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_err_len", err_len, 0);
        chk("mid_rst_err_ovf", err_ovf, 0);
        step();
        chk("mid_post_level", level, 0);

`ifdef EVA_RBUF_LEN_CHK_EN
        // Missing rlast on a 2-beat burst.
        m_rready = 1'b1;
        ar_hs    = 1'b1;
        ar_len   = 6'd1;
        step();
        ar_hs = 1'b0;
        send(DW'(1), 1'b0);
        chk("len_b1", err_len, 0);
        send(DW'(2), 1'b0);
        chk("len_b2", err_len, 1);
        send(DW'(3), 1'b1);
        chk("len_b3", err_len, 1);
        chk("len_b3_data", m_rdata, 3);
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        step();
        chk("len_sticky", err_len, 1);
        chk("len_level", level, 0);

        // AR queue overflow, then beat with no pending AR.
        do_reset();
        ar_hs  = 1'b1;
        ar_len = 6'd0;
        repeat (4) step();
        chk("ovf_4th", err_ovf, 0);
        step();
        chk("ovf_5th", err_ovf, 1);
        do_reset();
        send(DW'(7), 1'b1);
        s_rvalid = 1'b0;
        chk("ovf_no_ar", err_ovf, 1);
        step();
`endif

        // Random traffic: toggling sink first, then random sink.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c < 1000) m_rready = (c % 2 == 0);
            else m_rready = ($urandom_range(0, 3) != 0);
            s_rvalid = ($urandom_range(0, 2) != 0);
            s_rid    = IDW'($urandom);
            s_ruser  = UW'($urandom);
            s_rdata  = {$urandom, $urandom, $urandom, $urandom};
            s_rlast  = ($urandom_range(0, 3) == 0);
            s_rresp  = 2'($urandom);
            ar_hs    = ($urandom_range(0, 3) == 0);
            ar_len   = 6'($urandom_range(0, 3));
            arest    = ($urandom_range(0, 599) == 0);
            step();
        end
        arest    = 1'b0;
        s_rvalid = 1'b0;
        ar_hs    = 1'b0;
        m_rready = 1'b1;
        repeat (DEPTH + 2) step();
        chk("rand_drained", level, 0);
        chk("rand_mvalid", m_rvalid, 0);
`ifndef EVA_RBUF_LEN_CHK_EN
        chk("nochk_err_len", err_len, 0);
        chk("nochk_err_ovf", err_ovf, 0);
`endif
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
